// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the redirect-source encoding.
package cpu_pkg;

    localparam int unsigned PC_WIDTH     = 32;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;
    localparam int unsigned PC_INC       = 4;

    // Which source supplies the next PC, ordered lowest to highest priority.
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_J    = 3'd2,
        SRC_JR   = 3'd3,
        SRC_ERET = 3'd4,
        SRC_EXC  = 3'd5
    } redirect_src_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation and priority selection.
module pc_target_calc
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned INC   = PC_INC
) (
    input  logic [WIDTH-1:0] i_ctl_pc,
    input  logic [15:0]      i_br_imm,
    input  logic [25:0]      i_j_index,
    input  logic [WIDTH-1:0] i_jr_target,
    input  logic             i_exc_req,
    input  logic             i_eret,
    input  logic             i_jr_taken,
    input  logic             i_j_taken,
    input  logic             i_br_taken,
    output logic [WIDTH-1:0] o_tgt_c,
    output redirect_src_e    o_src_c
);

    // Bits 27:0 are replaced by the jump field; the upper bits come from ctl_pc + INC.
    localparam logic [WIDTH-1:0] J_HI_MASK = ~WIDTH'(28'hFFF_FFFF);

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_br_off;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_j_tgt;

    assign w_seq    = i_ctl_pc + WIDTH'(INC);
    assign w_br_off = WIDTH'($signed({i_br_imm, 2'b00}));
    assign w_br_tgt = w_seq + w_br_off;
    assign w_j_tgt  = (w_seq & J_HI_MASK) | WIDTH'({i_j_index, 2'b00});

    // Priority: exception > eret > jr > j > br; target only meaningful for jr/j/br.
    always_comb begin
        o_tgt_c = '0;
        o_src_c = SRC_SEQ;
        if (i_exc_req) begin
            o_src_c = SRC_EXC;
        end else if (i_eret) begin
            o_src_c = SRC_ERET;
        end else if (i_jr_taken) begin
            o_src_c = SRC_JR;
            o_tgt_c = i_jr_target;
        end else if (i_j_taken) begin
            o_src_c = SRC_J;
            o_tgt_c = w_j_tgt;
        end else if (i_br_taken) begin
            o_src_c = SRC_BR;
            o_tgt_c = w_br_tgt;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with stall handling and a one-entry redirect buffer.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
    parameter int unsigned      INC       = PC_INC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [WIDTH-1:0] ctl_pc,
    input  logic             br_taken,
    input  logic [15:0]      br_imm,
    input  logic             j_taken,
    input  logic [25:0]      j_index,
    input  logic             jr_taken,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redirect_pending,
    output logic             adel
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_tgt;
    logic             r_pend_valid;
    logic             r_adel;

    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pend_tgt_nxt;
    logic             w_pend_valid_nxt;
    logic             w_adel_nxt;
    logic             w_load;
    logic [WIDTH-1:0] w_tgt;
    redirect_src_e    w_src;

    pc_target_calc #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_target_calc (
        .i_ctl_pc    (ctl_pc),
        .i_br_imm    (br_imm),
        .i_j_index   (j_index),
        .i_jr_target (jr_target),
        .i_exc_req   (exc_req),
        .i_eret      (eret),
        .i_jr_taken  (jr_taken),
        .i_j_taken   (j_taken),
        .i_br_taken  (br_taken),
        .o_tgt_c     (w_tgt),
        .o_src_c     (w_src)
    );

    // PC, redirect buffer and misalignment flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_VEC;
            r_pend_tgt   <= '0;
            r_pend_valid <= 1'b0;
            r_adel       <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_pend_tgt   <= w_pend_tgt_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_adel       <= w_adel_nxt;
        end
    end

    // Next-state selection: exceptions bypass stall, other redirects park while stalled.
    always_comb begin
        w_pc_nxt         = r_pc;
        w_pend_tgt_nxt   = r_pend_tgt;
        w_pend_valid_nxt = r_pend_valid;
        w_load           = 1'b0;
        case (w_src)
            SRC_EXC: begin
                w_pc_nxt         = EXC_VEC;
                w_pend_valid_nxt = 1'b0;
                w_load           = 1'b1;
            end
            SRC_ERET: begin
                w_pc_nxt         = epc_in;
                w_pend_valid_nxt = 1'b0;
                w_load           = 1'b1;
            end
            SRC_JR, SRC_J, SRC_BR: begin
                if (stall) begin
                    w_pend_tgt_nxt   = w_tgt;
                    w_pend_valid_nxt = 1'b1;
                end else begin
                    w_pc_nxt         = w_tgt;
                    w_pend_valid_nxt = 1'b0;
                    w_load           = 1'b1;
                end
            end
            default: begin
                if (!stall) begin
                    w_load = 1'b1;
                    if (r_pend_valid) begin
                        w_pc_nxt         = r_pend_tgt;
                        w_pend_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt = r_pc + WIDTH'(INC);
                    end
                end
            end
        endcase
        w_adel_nxt = w_load ? (w_pc_nxt[1:0] != 2'b00) : r_adel;
    end

    assign pc               = r_pc;
    assign pc_plus          = r_pc + WIDTH'(INC);
    assign redirect_pending = r_pend_valid;
    assign adel             = r_adel;

endmodule
